ram_bist: RTL and testbench

RAM_BIST -- requirements
Module: ram_bist

---
 rtl/ram_bist.sv | 186 ++++++++++++++++++
 tb/tb_ram_bist.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bist.sv
// ---------------------------------------------------------------------------
// ram_bist
//
// Built-in self test for a single-port synchronous RAM. A run writes every
// word with a pattern, then reads every word back and compares it with the
// same pattern. Mismatches are counted (saturating at 255), and the address
// of the first mismatch is kept.
//
// Pattern per address: the latched seed, or the seed XOR the address when
// mode is 1.
//
// Optional build macro: RAM_BIST_COMPLEMENT_EN
//   When defined, a second write/read/drain pass follows the first. It uses
//   the bitwise complement of the pattern, and its mismatches add to the same
//   error count and first-error address. The port list is the same in both
//   builds.
//
// Ports:
//   iClk           - clock; all state changes on its rising edge
//   iReset         - synchronous active-high reset, has priority over iStart
//   iStart         - start request, honoured only in IDLE or DONE
//   iMode          - 0 = constant pattern, 1 = pattern XOR address
//   iPattern       - seed pattern
//   oRamWR         - RAM write enable (high only in WRITE)
//   oRamAddress    - RAM address
//   oRamWriteData  - RAM write data
//   iRamReadData   - RAM read data, valid one cycle after its address
//   oBusy          - high in WRITE, READ and DRAIN
//   oDone          - high in DONE
//   oPass          - high in DONE when no mismatch was seen
//   oErrCount      - number of mismatching words, saturating at 255
//   oFirstErrAddr  - address of the first mismatching word
// ---------------------------------------------------------------------------
module ram_bist #(
    parameter int ADDRWIDTH = 8,
    parameter int DATAWIDTH = 16
) (
    input  logic                 iClk,
    input  logic                 iReset,
    input  logic                 iStart,
    input  logic                 iMode,
    input  logic [DATAWIDTH-1:0] iPattern,
    output logic                 oRamWR,
    output logic [ADDRWIDTH-1:0] oRamAddress,
    output logic [DATAWIDTH-1:0] oRamWriteData,
    input  logic [DATAWIDTH-1:0] iRamReadData,
    output logic                 oBusy,
    output logic                 oDone,
    output logic                 oPass,
    output logic [7:0]           oErrCount,
    output logic [ADDRWIDTH-1:0] oFirstErrAddr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [ADDRWIDTH-1:0] addr_cnt;
    logic [ADDRWIDTH-1:0] cmp_addr;
    logic                 cmp_valid;
    logic                 mode_q;
    logic                 comp_q;
    logic [DATAWIDTH-1:0] pattern_q;
    logic                 last_addr;
    logic                 mismatch;

    // Expected word for an address. It depends on the latched mode and seed,
    // and on whether the complement pass is running.
    function automatic logic [DATAWIDTH-1:0] expected_word(input logic [ADDRWIDTH-1:0] a);
        logic [DATAWIDTH-1:0] w;
        w = mode_q ? (pattern_q ^ DATAWIDTH'(a)) : pattern_q;
        return comp_q ? ~w : w;
    endfunction

    assign last_addr = (addr_cnt == {ADDRWIDTH{1'b1}});

    // The read data seen this cycle belongs to the address presented on the
    // previous cycle, so the comparison uses the delayed address.
    assign mismatch = cmp_valid && (iRamReadData != expected_word(cmp_addr));

    // State register
    always_ff @(posedge iClk) begin
        if (iReset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A start request is only honoured from IDLE or DONE,
    // so a start pulse during a run has no effect.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (iStart) begin
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (last_addr) begin
                    state_next = S_READ;
                end
            end
            S_READ: begin
                if (last_addr) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
`ifdef RAM_BIST_COMPLEMENT_EN
                state_next = comp_q ? S_DONE : S_WRITE;
`else
                state_next = S_DONE;
`endif
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath: address counter, latched configuration, compare pipeline and
    // error bookkeeping. The counter wraps from N-1 to 0 on its own, which
    // lines up with each WRITE->READ and READ->DRAIN transition.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            addr_cnt      <= '0;
            cmp_addr      <= '0;
            cmp_valid     <= 1'b0;
            mode_q        <= 1'b0;
            comp_q        <= 1'b0;
            pattern_q     <= '0;
            oErrCount     <= '0;
            oFirstErrAddr <= '0;
        end else begin
            cmp_valid <= (state == S_READ);
            cmp_addr  <= addr_cnt;
            case (state)
                S_IDLE, S_DONE: begin
                    if (iStart) begin
                        mode_q        <= iMode;
                        pattern_q     <= iPattern;
                        comp_q        <= 1'b0;
                        addr_cnt      <= '0;
                        oErrCount     <= '0;
                        oFirstErrAddr <= '0;
                    end
                end
                S_WRITE, S_READ: begin
                    addr_cnt <= addr_cnt + ADDRWIDTH'(1);
                end
                S_DRAIN: begin
`ifdef RAM_BIST_COMPLEMENT_EN
                    comp_q <= 1'b1;
`endif
                end
                default: ;
            endcase
            if (mismatch) begin
                if (oErrCount != 8'hFF) begin
                    oErrCount <= oErrCount + 8'd1;
                end
                if (oErrCount == 8'd0) begin
                    oFirstErrAddr <= cmp_addr;
                end
            end
        end
    end

    // Moore outputs. Write data is forced to zero outside WRITE, so the RAM
    // bus stays quiet when no write is in progress.
    always_comb begin
        oRamWR        = (state == S_WRITE);
        oRamAddress   = addr_cnt;
        oRamWriteData = (state == S_WRITE) ? expected_word(addr_cnt) : '0;
        oBusy         = (state == S_WRITE) || (state == S_READ) || (state == S_DRAIN);
        oDone         = (state == S_DONE);
        oPass         = (state == S_DONE) && (oErrCount == 8'd0);
    end

endmodule

// File: tb/tb_ram_bist.sv
// ---------------------------------------------------------------------------
// tb_ram_bist
//
// Directed bench for ram_bist. It contains a 256 x 16 synchronous-read RAM
// model with selectable faults:
//   0 = healthy
//   1 = bit 0 of word 8'h10 stuck at 0
//   2 = every read returns 0
// Each scenario task drives a run and checks its results against expected
// values worked out by hand.
// ---------------------------------------------------------------------------
module tb_ram_bist;

`ifdef RAM_BIST_COMPLEMENT_EN
    localparam int RUN_LEN = 1027;
    localparam bit COMP    = 1'b1;
`else
    localparam int RUN_LEN = 514;
    localparam bit COMP    = 1'b0;
`endif
    localparam int TIMEOUT = 5000;

    logic        iClk = 1'b0;
    logic        iReset;
    logic        iStart;
    logic        iMode;
    logic [15:0] iPattern;
    logic        oRamWR;
    logic [7:0]  oRamAddress;
    logic [15:0] oRamWriteData;
    logic [15:0] iRamReadData;
    logic        oBusy;
    logic        oDone;
    logic        oPass;
    logic [7:0]  oErrCount;
    logic [7:0]  oFirstErrAddr;

    int total = 0;
    int bad   = 0;
    int fault_mode = 0;

    logic [15:0] mem [0:255];
    logic [15:0] rd_q;
    logic [7:0]  rd_addr_q;

    ram_bist #(.ADDRWIDTH(8), .DATAWIDTH(16)) dut (
        .iClk          (iClk),
        .iReset        (iReset),
        .iStart        (iStart),
        .iMode         (iMode),
        .iPattern      (iPattern),
        .oRamWR        (oRamWR),
        .oRamAddress   (oRamAddress),
        .oRamWriteData (oRamWriteData),
        .iRamReadData  (iRamReadData),
        .oBusy         (oBusy),
        .oDone         (oDone),
        .oPass         (oPass),
        .oErrCount     (oErrCount),
        .oFirstErrAddr (oFirstErrAddr)
    );

    always #5 iClk = ~iClk;

    // Synchronous-read RAM model
    always @(posedge iClk) begin
        if (oRamWR) mem[oRamAddress] <= oRamWriteData;
        rd_q      <= mem[oRamAddress];
        rd_addr_q <= oRamAddress;
    end

    // Fault injection on the read path
    always_comb begin
        iRamReadData = rd_q;
        if (fault_mode == 2) iRamReadData = 16'h0000;
        else if (fault_mode == 1 && rd_addr_q == 8'h10) iRamReadData = rd_q & 16'hFFFE;
    end

    // Start a run and count rising edges until oDone is seen, giving up after
    // TIMEOUT edges. iStart can optionally be pulsed again after edge pulse_at.
    task automatic run_bist(input logic mode, input logic [15:0] pat,
                            input int pulse_at, output int cycles);
        bit seen;
        seen = 1'b0;
        cycles = 0;
        @(negedge iClk);
        iMode = mode;
        iPattern = pat;
        iStart = 1'b1;
        while (!seen && cycles < TIMEOUT) begin
            @(posedge iClk);
            cycles++;
            #1;
            iStart = (cycles == pulse_at);
            if (oDone) seen = 1'b1;
        end
        iStart = 1'b0;
        if (!seen) $display("[TB] FAIL timeout: no oDone within %0d cycles", TIMEOUT);
    endtask

    task automatic test_reset;
        iReset = 1'b1;
        iStart = 1'b1;
        iMode = 1'b1;
        iPattern = 16'hFFFF;
        repeat (3) @(posedge iClk);
        #1;
        total++; if (oRamWR !== 1'b0)         begin bad++; $display("[TB] FAIL reset_wr got=%b exp=0", oRamWR); end
        total++; if (oRamAddress !== 8'h00)   begin bad++; $display("[TB] FAIL reset_addr got=%h exp=00", oRamAddress); end
        total++; if (oRamWriteData !== 16'h0) begin bad++; $display("[TB] FAIL reset_wdata got=%h exp=0000", oRamWriteData); end
        total++; if (oBusy !== 1'b0)          begin bad++; $display("[TB] FAIL reset_busy got=%b exp=0", oBusy); end
        total++; if (oDone !== 1'b0)          begin bad++; $display("[TB] FAIL reset_done got=%b exp=0", oDone); end
        total++; if (oPass !== 1'b0)          begin bad++; $display("[TB] FAIL reset_pass got=%b exp=0", oPass); end
        total++; if (oErrCount !== 8'h00)     begin bad++; $display("[TB] FAIL reset_err got=%h exp=00", oErrCount); end
        total++; if (oFirstErrAddr !== 8'h00) begin bad++; $display("[TB] FAIL reset_first got=%h exp=00", oFirstErrAddr); end
        iReset = 1'b0;
        iStart = 1'b0;
        @(posedge iClk);
        #1;
        total++; if (oBusy !== 1'b0) begin bad++; $display("[TB] FAIL reset_priority_busy got=%b exp=0", oBusy); end
    endtask

    task automatic test_constant;
        int cycles;
        int wrong;
        logic [15:0] exp_word;
        fault_mode = 0;
        run_bist(1'b0, 16'hA5A5, 0, cycles);
        total++; if (cycles !== RUN_LEN)     begin bad++; $display("[TB] FAIL const_len got=%0d exp=%0d", cycles, RUN_LEN); end
        total++; if (oPass !== 1'b1)         begin bad++; $display("[TB] FAIL const_pass got=%b exp=1", oPass); end
        total++; if (oErrCount !== 8'h00)    begin bad++; $display("[TB] FAIL const_err got=%h exp=00", oErrCount); end
        total++; if (oBusy !== 1'b0)         begin bad++; $display("[TB] FAIL const_busy got=%b exp=0", oBusy); end
        exp_word = COMP ? 16'h5A5A : 16'hA5A5;
        wrong = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== exp_word) wrong++;
        total++; if (wrong !== 0) begin bad++; $display("[TB] FAIL const_mem wrong_words got=%0d exp=0", wrong); end
    endtask

    task automatic test_xor;
        int cycles;
        fault_mode = 0;
        run_bist(1'b1, 16'h1200, 0, cycles);
        total++; if (cycles !== RUN_LEN) begin bad++; $display("[TB] FAIL xor_len got=%0d exp=%0d", cycles, RUN_LEN); end
        total++; if (oPass !== 1'b1)     begin bad++; $display("[TB] FAIL xor_pass got=%b exp=1", oPass); end
        total++; if (mem[8'h34] !== (COMP ? 16'hEDCB : 16'h1234))
            begin bad++; $display("[TB] FAIL xor_word34 got=%h exp=%h", mem[8'h34], COMP ? 16'hEDCB : 16'h1234); end
        total++; if (mem[8'hFF] !== (COMP ? 16'hED00 : 16'h12FF))
            begin bad++; $display("[TB] FAIL xor_wordFF got=%h exp=%h", mem[8'hFF], COMP ? 16'hED00 : 16'h12FF); end
    endtask

    task automatic test_stuck_bit;
        int cycles;
        fault_mode = 1;
        run_bist(1'b0, 16'hFFFF, 0, cycles);
        total++; if (oDone !== 1'b1)          begin bad++; $display("[TB] FAIL stuck_done got=%b exp=1", oDone); end
        total++; if (oPass !== 1'b0)          begin bad++; $display("[TB] FAIL stuck_pass got=%b exp=0", oPass); end
        total++; if (oErrCount !== 8'd1)      begin bad++; $display("[TB] FAIL stuck_err got=%h exp=01", oErrCount); end
        total++; if (oFirstErrAddr !== 8'h10) begin bad++; $display("[TB] FAIL stuck_first got=%h exp=10", oFirstErrAddr); end
        fault_mode = 0;
    endtask

    task automatic test_saturate;
        int cycles;
        fault_mode = 2;
        run_bist(1'b0, 16'h0001, 0, cycles);
        total++; if (cycles !== RUN_LEN)      begin bad++; $display("[TB] FAIL sat_len got=%0d exp=%0d", cycles, RUN_LEN); end
        total++; if (oPass !== 1'b0)          begin bad++; $display("[TB] FAIL sat_pass got=%b exp=0", oPass); end
        total++; if (oErrCount !== 8'hFF)     begin bad++; $display("[TB] FAIL sat_err got=%h exp=ff", oErrCount); end
        total++; if (oFirstErrAddr !== 8'h00) begin bad++; $display("[TB] FAIL sat_first got=%h exp=00", oFirstErrAddr); end
        fault_mode = 0;
    endtask

    task automatic test_reset_mid_write;
        int cycles;
        @(negedge iClk);
        iMode = 1'b1;
        iPattern = 16'h1200;
        iStart = 1'b1;
        @(posedge iClk);
        #1;
        iStart = 1'b0;
        total++; if (oRamWR !== 1'b1 || oRamAddress !== 8'h00 || oRamWriteData !== 16'h1200)
            begin bad++; $display("[TB] FAIL first_write got=%b/%h/%h exp=1/00/1200", oRamWR, oRamAddress, oRamWriteData); end
        repeat (49) @(posedge iClk);
        #1;
        total++; if (oRamAddress !== 8'd49 || oRamWriteData !== 16'h1231)
            begin bad++; $display("[TB] FAIL write50 got=%h/%h exp=31/1231", oRamAddress, oRamWriteData); end
        iReset = 1'b1;
        @(posedge iClk);
        #1;
        iReset = 1'b0;
        total++; if (oRamWR !== 1'b0)         begin bad++; $display("[TB] FAIL midrst_wr got=%b exp=0", oRamWR); end
        total++; if (oBusy !== 1'b0)          begin bad++; $display("[TB] FAIL midrst_busy got=%b exp=0", oBusy); end
        total++; if (oRamAddress !== 8'h00)   begin bad++; $display("[TB] FAIL midrst_addr got=%h exp=00", oRamAddress); end
        total++; if (oRamWriteData !== 16'h0) begin bad++; $display("[TB] FAIL midrst_wdata got=%h exp=0000", oRamWriteData); end
        total++; if (oDone !== 1'b0 || oPass !== 1'b0)
            begin bad++; $display("[TB] FAIL midrst_done_pass got=%b/%b exp=0/0", oDone, oPass); end
        total++; if (oErrCount !== 8'h00 || oFirstErrAddr !== 8'h00)
            begin bad++; $display("[TB] FAIL midrst_err got=%h/%h exp=00/00", oErrCount, oFirstErrAddr); end
        run_bist(1'b0, 16'h3C3C, 0, cycles);
        total++; if (cycles !== RUN_LEN) begin bad++; $display("[TB] FAIL midrst_rerun_len got=%0d exp=%0d", cycles, RUN_LEN); end
        total++; if (oPass !== 1'b1)     begin bad++; $display("[TB] FAIL midrst_rerun_pass got=%b exp=1", oPass); end
    endtask

    task automatic test_start_mid_read;
        int cycles;
        fault_mode = 0;
        run_bist(1'b1, 16'h0F0F, 300, cycles);
        total++; if (cycles !== RUN_LEN) begin bad++; $display("[TB] FAIL midread_len got=%0d exp=%0d", cycles, RUN_LEN); end
        total++; if (oPass !== 1'b1)     begin bad++; $display("[TB] FAIL midread_pass got=%b exp=1", oPass); end
    endtask

    initial begin
        iReset = 1'b1;
        iStart = 1'b0;
        iMode = 1'b0;
        iPattern = 16'h0000;
        test_reset();
        test_constant();
        test_xor();
        test_stuck_bit();
        test_saturate();
        test_reset_mid_write();
        test_start_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
